// File: rtl/response_checker.sv
// Response checker: accepts a vector plus its expected DUV output, waits for the DUV
// to settle, compares once, and keeps pass/fail counts and a first-failure record.
module response_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int VEC_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [VEC_W-1:0] exp_out,
  input  logic [VEC_W-1:0] dut_out,
  input  logic             end_req,
  output logic [7:0]       pass_cnt,
  output logic [7:0]       fail_cnt,
  output logic             err,
  output logic [7:0]       ff_idx,
  output logic [VEC_W-1:0] ff_got,
  output logic [VEC_W-1:0] ff_exp,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, REPORT} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t           state_q,     state_d;
  logic [7:0]       cnt_q,       cnt_d;
  logic [VEC_W-1:0] exp_lat_q,   exp_lat_d;
  logic [7:0]       idx_q,       idx_d;
  logic [7:0]       pass_q,      pass_d;
  logic [7:0]       fail_q,      fail_d;
  logic             err_q,       err_d;
  logic [7:0]       ff_idx_q,    ff_idx_d;
  logic [VEC_W-1:0] ff_got_q,    ff_got_d;
  logic [VEC_W-1:0] ff_exp_q,    ff_exp_d;
  logic             end_pend_q,  end_pend_d;
  logic             vec_ready_q, vec_ready_d;
  logic             done_q,      done_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_lat_d  = exp_lat_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = err_q;
    ff_idx_d   = ff_idx_q;
    ff_got_d   = ff_got_q;
    ff_exp_d   = ff_exp_q;
    end_pend_d = end_pend_q;

    case (state_q)
      IDLE: begin
        // A pending or live end request wins over a vector offered in the same cycle.
        if (end_req || end_pend_q) begin
          state_d = REPORT;
        end else if (vec_valid) begin
          exp_lat_d = exp_out;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (end_req) end_pend_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      COMPARE: begin
        if (end_req) end_pend_d = 1'b1;
        idx_d = sat_inc(idx_q);
        if (dut_out == exp_lat_q) begin
          pass_d = sat_inc(pass_q);
        end else begin
          fail_d = sat_inc(fail_q);
          err_d  = 1'b1;
          if (!err_q) begin
            ff_idx_d = idx_q;
            ff_got_d = dut_out;
            ff_exp_d = exp_lat_q;
          end
        end
        state_d = IDLE;
      end
      REPORT: begin
        state_d = REPORT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    vec_ready_d = (state_d == IDLE);
    done_d      = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    exp_lat_q <= exp_lat_d;
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      idx_q       <= 8'd0;
      pass_q      <= 8'd0;
      fail_q      <= 8'd0;
      err_q       <= 1'b0;
      ff_idx_q    <= 8'd0;
      ff_got_q    <= '0;
      ff_exp_q    <= '0;
      end_pend_q  <= 1'b0;
      vec_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      ff_idx_q    <= ff_idx_d;
      ff_got_q    <= ff_got_d;
      ff_exp_q    <= ff_exp_d;
      end_pend_q  <= end_pend_d;
      vec_ready_q <= vec_ready_d;
      done_q      <= done_d;
    end
  end

  assign vec_ready = vec_ready_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign err       = err_q;
  assign ff_idx    = ff_idx_q;
  assign ff_got    = ff_got_q;
  assign ff_exp    = ff_exp_q;
  assign done      = done_q;

endmodule

// File: tb/tb_response_checker.sv
// Scoreboard bench for response_checker: each vector's expected/actual pair is queued
// at acceptance and folded into a reference model when the checker finishes it.
module tb_response_checker;

  localparam int SC = 4;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vec_valid = 1'b0;
  logic          vec_ready;
  logic [VW-1:0] exp_out = '0;
  logic [VW-1:0] dut_out = '0;
  logic          end_req = 1'b0;
  logic [7:0]    pass_cnt, fail_cnt, ff_idx;
  logic          err, done;
  logic [VW-1:0] ff_got, ff_exp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [VW-1:0] e;
    logic [VW-1:0] d;
  } item_t;
  item_t sb[$];

  int            m_pass, m_fail, m_idx;
  logic          m_err;
  logic [7:0]    m_ffidx;
  logic [VW-1:0] m_ffgot, m_ffexp;

  response_checker #(.SETTLE_CYCLES(SC), .VEC_W(VW)) dut (
    .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .exp_out(exp_out), .dut_out(dut_out), .end_req(end_req),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .ff_idx(ff_idx),
    .ff_got(ff_got), .ff_exp(ff_exp), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pass = 0; m_fail = 0; m_idx = 0; m_err = 1'b0;
    m_ffidx = '0; m_ffgot = '0; m_ffexp = '0;
  endtask

  function automatic logic [34:0] model_vec();
    return {8'(sat8(m_pass)), 8'(sat8(m_fail)), m_err, m_ffidx, m_ffgot, m_ffexp};
  endfunction

  function automatic logic [34:0] dut_vec();
    return {pass_cnt, fail_cnt, err, ff_idx, ff_got, ff_exp};
  endfunction

  // Offer one vector, wait (bounded) for the checker to return to IDLE, then retire it.
  task automatic run_vec(input logic [VW-1:0] e, input logic [VW-1:0] d,
                         input bit glitch, input int end_at, output int lat);
    item_t it;
    vec_valid = 1'b1;
    exp_out   = e;
    dut_out   = glitch ? (d ^ 5'h1F) : d;
    sb.push_back('{e: e, d: d});
    tick();
    vec_valid = 1'b0;
    exp_out   = ~e;
    lat = 0;
    while (vec_ready !== 1'b1 && lat < 40) begin
      end_req = (lat == end_at);
      if (glitch && lat == SC - 1) dut_out = d;
      tick();
      lat++;
    end
    end_req = 1'b0;
    dut_out = 5'($urandom);
    if (lat >= 40) begin
      total++; bad++;
      $display("FAIL vec_timeout got=no_ready want=ready_within_40");
    end
    it = sb.pop_front();
    if (it.e == it.d) begin
      m_pass++;
    end else begin
      if (!m_err) begin
        m_ffidx = 8'(sat8(m_idx));
        m_ffgot = it.d;
        m_ffexp = it.e;
      end
      m_fail++;
      m_err = 1'b1;
    end
    m_idx++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    total++;
    if ({dut_vec(), done} !== 36'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {dut_vec(), done});
    end
    total++;
    if (vec_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", vec_ready);
    end
  endtask

  task automatic test_pass();
    int lat;
    run_vec(5'h01, 5'h01, 1'b0, -1, lat);
    total++;
    if (lat !== SC + 1) begin
      bad++; $display("FAIL pass_latency got=%0d want=%0d", lat, SC + 1);
    end
    total++;
    if (dut_vec() !== model_vec() || pass_cnt !== 8'd1 || err !== 1'b0) begin
      bad++; $display("FAIL pass_counts got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_fail();
    int lat;
    run_vec(5'h04, 5'h05, 1'b0, -1, lat);
    total++;
    if (dut_vec() !== model_vec() || ff_got !== 5'h05 || ff_exp !== 5'h04 || ff_idx !== 8'd1) begin
      bad++; $display("FAIL first_fail got=%h want=%h", dut_vec(), model_vec());
    end
    run_vec(5'h07, 5'h00, 1'b0, -1, lat);
    total++;
    if (dut_vec() !== model_vec() || fail_cnt !== 8'd2 || ff_got !== 5'h05) begin
      bad++; $display("FAIL second_fail got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_glitch();
    int lat;
    run_vec(5'h0A, 5'h0A, 1'b1, -1, lat);
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL glitch_pass got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_end_in_settle();
    int lat;
    logic [34:0] snap;
    run_vec(5'h13, 5'h13, 1'b0, 1, lat);
    total++;
    if (dut_vec() !== model_vec() || done !== 1'b0) begin
      bad++; $display("FAIL end_inflight got=%h want=%h", dut_vec(), model_vec());
    end
    tick();
    total++;
    if (done !== 1'b1 || vec_ready !== 1'b0) begin
      bad++; $display("FAIL end_report got=%b%b want=10", done, vec_ready);
    end
    snap = model_vec();
    vec_valid = 1'b1; exp_out = 5'h02; dut_out = 5'h1D; end_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 5) end_req = 1'b0;
    end
    vec_valid = 1'b0;
    total++;
    if (dut_vec() !== snap || done !== 1'b1 || vec_ready !== 1'b0) begin
      bad++; $display("FAIL report_frozen got=%h want=%h", dut_vec(), snap);
    end
  endtask

  task automatic test_rst_mid_settle();
    int lat;
    vec_valid = 1'b1; exp_out = 5'h03; dut_out = 5'h03;
    tick();
    vec_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    model_reset();
    total++;
    if ({dut_vec(), done} !== 36'd0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h want=0", {dut_vec(), done});
    end
    rst = 1'b0;
    total++;
    if (vec_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_ready got=%b want=1", vec_ready);
    end
    tick(); tick(); tick(); tick(); tick(); tick();
    total++;
    if (pass_cnt !== 8'd0 || vec_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_discard got=%0d want=0", pass_cnt);
    end
    run_vec(5'h11, 5'h11, 1'b0, -1, lat);
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL rst_mid_after got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [VW-1:0] v;
    for (int i = 0; i < 300; i++) begin
      v = 5'($urandom);
      run_vec(v, v, 1'b0, -1, lat);
      if (i == 254 || i == 299) begin
        total++;
        if (dut_vec() !== model_vec()) begin
          bad++; $display("FAIL sat_pass_%0d got=%h want=%h", i, dut_vec(), model_vec());
        end
      end
    end
    run_vec(5'h15, 5'h0A, 1'b0, -1, lat);
    total++;
    if (dut_vec() !== model_vec() || ff_idx !== 8'd255 || pass_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_index got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_end_with_valid();
    logic [34:0] snap;
    snap = model_vec();
    vec_valid = 1'b1; exp_out = 5'h06; dut_out = 5'h01; end_req = 1'b1;
    tick();
    vec_valid = 1'b0; end_req = 1'b0;
    total++;
    if (done !== 1'b1 || vec_ready !== 1'b0) begin
      bad++; $display("FAIL end_valid_report got=%b%b want=10", done, vec_ready);
    end
    tick(); tick(); tick(); tick(); tick(); tick();
    total++;
    if (dut_vec() !== snap) begin
      bad++; $display("FAIL end_valid_counts got=%h want=%h", dut_vec(), snap);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_fail();
    test_glitch();
    test_end_in_settle();
    test_reset();
    test_rst_mid_settle();
    test_saturation();
    test_end_with_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
